// File: rtl/dac_i2s_tx_param_pkg.sv
// Shared definitions for the stereo serial-audio DAC transmitter.
// Contents: serial format encoding, default widths/dividers and a
// parameter sanity check used at elaboration by the top level.
package dac_i2s_tx_param_pkg;

  // Serial format, sampled once per frame.
  typedef enum logic {
    FMT_I2S = 1'b0,  // data delayed one BCK after the LRCK edge
    FMT_LJ  = 1'b1   // MSB coincides with the LRCK edge
  } fmt_e;

  localparam int DEF_DATA_W        = 24;
  localparam int DEF_SLOT_W        = 32;
  localparam int DEF_BCK_HALF_DIV  = 16;
  localparam int DEF_SCKI_HALF_DIV = 4;
  localparam int DEF_UCNT_W        = 16;

  // True when the parameter set describes a buildable transmitter.
  function automatic bit params_ok(input int data_w, input int slot_w,
                                   input int bck_half, input int scki_half);
    return (data_w >= 16) && (data_w < slot_w) &&
           (bck_half >= 2) && (scki_half >= 1);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Clock and frame-position generator for the DAC transmitter.
// Ports:
//   clk, rst      core clock and synchronous active-high reset
//   dac_scki      free-running DAC system clock
//   dac_bck       bit clock
//   dac_lrck      word select, high during the right slot
//   fall_strobe   one-cycle strobe in the cycle whose edge drops dac_bck
//   frame_start   fall_strobe on which bit_cnt wraps back to 0
//   p             position inside the current slot (bit_cnt mod SLOT_W)
module i2s_clk_gen #(
  parameter int SLOT_W        = 32,
  parameter int BCK_HALF_DIV  = 16,
  parameter int SCKI_HALF_DIV = 4,
  localparam int PW = $clog2(SLOT_W)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          dac_scki,
  output logic          dac_bck,
  output logic          dac_lrck,
  output logic          fall_strobe,
  output logic          frame_start,
  output logic [PW-1:0] p
);

  localparam int BW  = $clog2(2 * SLOT_W);
  localparam int SCW = $clog2(SCKI_HALF_DIV + 1);
  localparam int BCW = $clog2(BCK_HALF_DIV + 1);

  logic [SCW-1:0] scki_cnt;
  logic [BCW-1:0] bck_cnt;
  logic [BW-1:0]  bit_cnt;
  logic           scki_tc;
  logic           bck_tc;

  assign scki_tc     = (scki_cnt == SCW'(SCKI_HALF_DIV - 1));
  assign bck_tc      = (bck_cnt == BCW'(BCK_HALF_DIV - 1));
  assign fall_strobe = bck_tc & dac_bck;
  assign frame_start = fall_strobe & (bit_cnt == BW'(2 * SLOT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      scki_cnt <= '0;
      bck_cnt  <= '0;
      bit_cnt  <= '0;
      dac_scki <= 1'b0;
      dac_bck  <= 1'b0;
    end else begin
      scki_cnt <= scki_tc ? '0 : scki_cnt + 1'b1;
      if (scki_tc) dac_scki <= ~dac_scki;
      bck_cnt <= bck_tc ? '0 : bck_cnt + 1'b1;
      if (bck_tc) dac_bck <= ~dac_bck;
      // bit_cnt moves on the same edge that drops BCK, so everything
      // derived from it changes on the falling edge.
      if (fall_strobe) bit_cnt <= frame_start ? '0 : bit_cnt + 1'b1;
    end
  end

  assign dac_lrck = (bit_cnt >= BW'(SLOT_W));
  assign p        = dac_lrck ? PW'(bit_cnt - BW'(SLOT_W)) : PW'(bit_cnt);

endmodule

// File: rtl/dac_i2s_tx_param.sv
// Parametrised stereo serial-audio transmitter (master) for a
// PCM5102A-class DAC. Generates SCKI/BCK/LRCK and serialises one stereo
// frame per LRCK period, MSB first, in I2S or left-justified format.
// Ports:
//   cmn_clk, cmn_rst         core clock, synchronous active-high reset
//   s_tvalid/s_tready        frame handshake
//   s_tdata_L/s_tdata_R      two's complement samples
//   fmt_lj, mute             format and mute, sampled at frame start
//   dac_scki/bck/lrck/data   DAC serial interface
//   underrun, underrun_cnt   frame-start pulse with no frame held, and
//                            its saturating count
//
// Handshake: a frame transfers on every cycle where s_tvalid and s_tready
// are both high. s_tready is a register that is high exactly when the
// one-frame holding buffer is empty; the source may hold s_tvalid and data
// until the transfer and must not change data while s_tvalid waits.
module dac_i2s_tx_param
  import dac_i2s_tx_param_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int SLOT_W        = DEF_SLOT_W,
  parameter int BCK_HALF_DIV  = DEF_BCK_HALF_DIV,
  parameter int SCKI_HALF_DIV = DEF_SCKI_HALF_DIV,
  parameter int UCNT_W        = DEF_UCNT_W
) (
  input  logic              cmn_clk,
  input  logic              cmn_rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata_L,
  input  logic [DATA_W-1:0] s_tdata_R,
  input  logic              fmt_lj,
  input  logic              mute,
  output logic              dac_scki,
  output logic              dac_bck,
  output logic              dac_lrck,
  output logic              dac_data,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int PW = $clog2(SLOT_W);

  if (!params_ok(DATA_W, SLOT_W, BCK_HALF_DIV, SCKI_HALF_DIV)) begin : g_bad_params
    $error("dac_i2s_tx_param: illegal parameter set");
  end

  logic          fall_strobe;
  logic          frame_start;
  logic [PW-1:0] p;

  i2s_clk_gen #(
    .SLOT_W       (SLOT_W),
    .BCK_HALF_DIV (BCK_HALF_DIV),
    .SCKI_HALF_DIV(SCKI_HALF_DIV)
  ) u_clk_gen (
    .clk        (cmn_clk),
    .rst        (cmn_rst),
    .dac_scki   (dac_scki),
    .dac_bck    (dac_bck),
    .dac_lrck   (dac_lrck),
    .fall_strobe(fall_strobe),
    .frame_start(frame_start),
    .p          (p)
  );

  logic              start_pending;
  logic              frame_load;
  logic              accept;
  logic              hold_full;
  logic              hold_full_n;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic [DATA_W-1:0] frame_l, frame_r;
  logic [DATA_W-1:0] sel_word;
  logic [DATA_W-1:0] shifted;
  fmt_e              fmt_r;

  // The frame that begins at bit_cnt = 0 straight after reset has no wrap
  // strobe of its own; start_pending stands in for it so that frame is
  // handled (and counted) like any other underrun.
  assign frame_load = (fall_strobe & frame_start) | start_pending;
  assign accept     = s_tvalid & s_tready;

  // Accept only happens while empty, so it never collides with a load
  // from a full buffer; the load decision uses the pre-cycle state.
  always_comb begin
    hold_full_n = hold_full;
    if (frame_load) hold_full_n = 1'b0;
    if (accept)     hold_full_n = 1'b1;
  end

  always_ff @(posedge cmn_clk) begin
    if (cmn_rst) begin
      start_pending <= 1'b1;
      hold_full     <= 1'b0;
      s_tready      <= 1'b0;
      hold_l        <= '0;
      hold_r        <= '0;
      frame_l       <= '0;
      frame_r       <= '0;
      fmt_r         <= FMT_I2S;
      underrun      <= 1'b0;
      underrun_cnt  <= '0;
    end else begin
      start_pending <= 1'b0;
      hold_full     <= hold_full_n;
      s_tready      <= ~hold_full_n;
      if (accept) begin
        hold_l <= s_tdata_L;
        hold_r <= s_tdata_R;
      end
      underrun <= frame_load & ~hold_full;
      if (frame_load) begin
        fmt_r <= fmt_e'(fmt_lj);
        if (hold_full && !mute) begin
          frame_l <= hold_l;
          frame_r <= hold_r;
        end else begin
          frame_l <= '0;
          frame_r <= '0;
        end
        if (!hold_full && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
      end
    end
  end

  // Serialiser: shift the active word so the wanted bit lands in the MSB.
  always_comb begin
    sel_word = dac_lrck ? frame_r : frame_l;
    shifted  = '0;
    dac_data = 1'b0;
    if (fmt_r == FMT_LJ) begin
      if (p < PW'(DATA_W)) begin
        shifted  = sel_word << p;
        dac_data = shifted[DATA_W-1];
      end
    end else begin
      if ((p != '0) && (p <= PW'(DATA_W))) begin
        shifted  = sel_word << (p - 1'b1);
        dac_data = shifted[DATA_W-1];
      end
    end
  end

endmodule

// File: tb/tb_dac_i2s_tx_param.sv
// Directed self-checking bench for dac_i2s_tx_param at default parameters.
module tb_dac_i2s_tx_param;

  logic        cmn_clk = 1'b0;
  logic        cmn_rst;
  logic        s_tvalid;
  logic        s_tready;
  logic [23:0] s_tdata_L;
  logic [23:0] s_tdata_R;
  logic        fmt_lj;
  logic        mute;
  logic        dac_scki;
  logic        dac_bck;
  logic        dac_lrck;
  logic        dac_data;
  logic        underrun;
  logic [15:0] underrun_cnt;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 cmn_clk = ~cmn_clk;

  dac_i2s_tx_param dut (
    .cmn_clk     (cmn_clk),
    .cmn_rst     (cmn_rst),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata_L   (s_tdata_L),
    .s_tdata_R   (s_tdata_R),
    .fmt_lj      (fmt_lj),
    .mute        (mute),
    .dac_scki    (dac_scki),
    .dac_bck     (dac_bck),
    .dac_lrck    (dac_lrck),
    .dac_data    (dac_data),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present a frame and hold it for the accepting edge
  task automatic send(input logic [23:0] l, input logic [23:0] r, output logic ok);
    int cyc;
    cyc = 0;
    while (!s_tready && cyc < 5000) begin
      @(negedge cmn_clk);
      cyc++;
    end
    ok        = s_tready;
    s_tdata_L = l;
    s_tdata_R = r;
    s_tvalid  = 1'b1;
    @(negedge cmn_clk);
    s_tvalid  = 1'b0;
  endtask

  // wait for dac_lrck to move to lvl; reports underrun seen with the edge
  task automatic wait_lrck(input logic lvl, output int cyc, output logic ur,
                           output logic data_seen, output logic ok);
    logic prev;
    prev = dac_lrck;
    cyc = 0; ur = 1'b0; ok = 1'b0; data_seen = 1'b0;
    while (cyc < 5000) begin
      @(negedge cmn_clk);
      cyc++;
      if (dac_data) data_seen = 1'b1;
      if (dac_lrck === lvl && prev !== lvl) begin
        ok = 1'b1;
        ur = underrun;
        break;
      end
      prev = dac_lrck;
    end
  endtask

  task automatic wait_bck_rise(output int cyc);
    logic prev;
    prev = dac_bck;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge cmn_clk);
      cyc++;
      if (dac_bck && !prev) break;
      prev = dac_bck;
    end
  endtask

  // capture the next 64 BCK rising edges; bits[63-n] is slot bit n in time order
  task automatic capture(output logic [63:0] bits, output logic [63:0] lrs,
                         output logic rdy_seen, output logic ok);
    logic prev;
    int   cyc;
    int   n;
    prev = dac_bck;
    cyc = 0; n = 0; ok = 1'b1; rdy_seen = 1'b0;
    bits = '0; lrs = '0;
    while (n < 64) begin
      @(negedge cmn_clk);
      cyc++;
      if (s_tready) rdy_seen = 1'b1;
      if (dac_bck && !prev) begin
        bits[63-n] = dac_data;
        lrs[63-n]  = dac_lrck;
        n++;
      end
      prev = dac_bck;
      if (cyc > 3000) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int          cyc;
    int          rises;
    logic        ur, ds, ds2, ok, rdy;
    logic        prev_scki;
    logic [63:0] bits, lrs;

    cmn_rst = 1'b1; s_tvalid = 1'b0; s_tdata_L = '0; s_tdata_R = '0;
    fmt_lj = 1'b0; mute = 1'b0;
    repeat (5) @(negedge cmn_clk);

    // reset state
    check("rst_tready", s_tready, 0);
    check("rst_outputs", {dac_scki, dac_bck, dac_lrck, dac_data, underrun}, 0);
    check("rst_ucnt", underrun_cnt, 0);

    // release: ready next cycle, start-up frame counts as an underrun
    cmn_rst = 1'b0;
    @(negedge cmn_clk);
    check("rel_tready", s_tready, 1);
    check("rel_underrun", underrun, 1);
    check("rel_ucnt", underrun_cnt, 1);

    prev_scki = dac_scki; rises = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge cmn_clk);
      if (dac_scki && !prev_scki) rises++;
      prev_scki = dac_scki;
    end
    check("scki_rises_80cyc", rises, 10);

    wait_bck_rise(cyc);
    wait_bck_rise(cyc);
    check("bck_period", cyc, 32);

    wait_lrck(1'b0, cyc, ur, ds, ok);
    check("idle_f1_ok", ok, 1);
    check("idle_f1_underrun", ur, 1);
    check("idle_f1_ucnt", underrun_cnt, 2);
    wait_lrck(1'b0, cyc, ur, ds2, ok);
    check("lrck_period", cyc, 2048);
    check("idle_f2_underrun", ur, 1);
    check("idle_ucnt3", underrun_cnt, 3);
    check("idle_data_zero", ds | ds2, 0);

    // I2S frame
    send(24'h800001, 24'h7FFFFE, ok);
    check("i2s_send", ok, 1);
    check("i2s_tready_full", s_tready, 0);
    wait_lrck(1'b0, cyc, ur, ds, ok);
    check("i2s_no_underrun", ur, 0);
    check("i2s_tready_back", s_tready, 1);
    capture(bits, lrs, rdy, ok);
    check("i2s_cap_ok", ok, 1);
    check("i2s_left", bits[63:32], 64'h40000080);
    check("i2s_right", bits[31:0], 64'h3FFFFF00);
    check("i2s_lrck", lrs, 64'h00000000FFFFFFFF);

    // left-justified frame
    fmt_lj = 1'b1;
    send(24'hA5A5A5, 24'h123456, ok);
    check("lj_send", ok, 1);
    wait_lrck(1'b0, cyc, ur, ds, ok);
    check("lj_no_underrun", ur, 0);
    capture(bits, lrs, rdy, ok);
    check("lj_left", bits[63:32], 64'hA5A5A500);
    check("lj_right", bits[31:0], 64'h12345600);
    check("lj_lrck_left_low", lrs[63:32], 0);

    // muted frame
    fmt_lj = 1'b0;
    mute   = 1'b1;
    send(24'hFFFFFF, 24'hFFFFFF, ok);
    wait_lrck(1'b0, cyc, ur, ds, ok);
    mute = 1'b0;
    check("mute_no_underrun", ur, 0);
    check("mute_consumed", s_tready, 1);
    capture(bits, lrs, rdy, ok);
    check("mute_data", bits, 0);

    // accept in the exact frame-start cycle: capture ended at the last BCK
    // rise; the frame-start edge is the 16th rising clock edge after it
    repeat (15) @(negedge cmn_clk);
    s_tdata_L = 24'h123456; s_tdata_R = 24'h654321; s_tvalid = 1'b1;
    @(negedge cmn_clk);
    s_tvalid = 1'b0;
    check("coinc_underrun", underrun, 1);
    check("coinc_ucnt", underrun_cnt, 4);
    check("coinc_tready", s_tready, 0);
    check("coinc_lrck", dac_lrck, 0);
    capture(bits, lrs, rdy, ok);
    check("coinc_frame_zero", bits, 0);
    check("coinc_tready_held", rdy, 0);
    wait_lrck(1'b0, cyc, ur, ds, ok);
    check("coinc_next_no_underrun", ur, 0);
    check("coinc_next_tready", s_tready, 1);
    capture(bits, lrs, rdy, ok);
    check("coinc_next_frame", bits, 64'h091A2B0032A19080);

    // reset mid right slot with a frame held
    wait_lrck(1'b0, cyc, ur, ds, ok);
    check("pre_rst_underrun", ur, 1);
    send(24'hFFFFFF, 24'hFFFFFF, ok);
    wait_lrck(1'b1, cyc, ur, ds, ok);
    check("right_slot_ok", ok, 1);
    repeat (100) @(negedge cmn_clk);
    cmn_rst = 1'b1;
    @(negedge cmn_clk);
    check("mid_rst_tready", s_tready, 0);
    check("mid_rst_outputs", {dac_scki, dac_bck, dac_lrck, dac_data, underrun}, 0);
    check("mid_rst_ucnt", underrun_cnt, 0);
    cmn_rst = 1'b0;
    capture(bits, lrs, rdy, ok);
    check("post_rst_frame0", bits, 0);
    wait_lrck(1'b0, cyc, ur, ds, ok);
    check("post_rst_dropped_underrun", ur, 1);
    check("post_rst_ucnt", underrun_cnt, 2);
    capture(bits, lrs, rdy, ok);
    check("post_rst_frame1", bits, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
